// File: rtl/mux_pkg.sv
// Shared definitions for the parametrised registered multiplexer:
// mode encodings, output-stage state type and the width helper.
package mux_pkg;

    // Encodings of the mode input.
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // One-entry output register: empty or holding a word.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Number of bits needed to index n items (n >= 2 gives at least 1).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: holds the last-granted pointer and searches
// ptr+1, ptr+2, ... (wrapping) for the first valid channel. The pointer
// only moves when the parent reports that the grant was actually taken.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic [CHANNELS-1:0] valid_i,
    input  logic                advance_i,
    output logic [SEL_W-1:0]    grant_o,
    output logic                grant_exists_o
);

    // Pointer restarts at the last channel so the first search begins at 0.
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    // Rotating priority search starting just after the pointer.
    always_comb begin
        int                idx;
        logic              found;
        logic [CHANNELS-1:0] valid_sh;
        idx      = 0;
        found    = 1'b0;
        valid_sh = '0;
        grant_o  = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx      = (int'(ptr_q) + k) % CHANNELS;
            valid_sh = valid_i >> idx;
            if (!found && valid_sh[0]) begin
                found   = 1'b1;
                grant_o = idx[SEL_W-1:0];
            end
        end
        grant_exists_o = found;
    end

    // Pointer follows the taken grant; frozen otherwise.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && grant_exists_o) begin
            ptr_d = grant_o;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr_q <= PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_param_rr.sv
// Registered CHANNELS:1 multiplexer with per-channel valid/ready and a
// one-entry output register. Optional round-robin arbitration is built
// only when MUX_PARAM_RR_EN is defined; otherwise mode is ignored and the
// block works in selector mode only.
//
// Handshake: an input channel transfers on a rising edge where its
// valid_in and ready_out bits are both high; the output word transfers on
// an edge where valid_out and ready_in are both high. ready_out is
// combinational, at most one bit is set, and it never depends on ready_out
// of the consumer through a register, so a new word can load in the same
// edge the old one drains.
module mux_param_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 2,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS-1:0]       valid_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [CHANNELS-1:0]       ready_out,
    input  logic                      ready_in,
    output logic                      valid_out,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          chan_out
);

    out_state_e       state_q;
    out_state_e       state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [SEL_W-1:0] chan_q;
    logic [SEL_W-1:0] chan_d;

    logic             can_load;
    logic             sel_exists;
    logic             grant_exists;
    logic [SEL_W-1:0] grant_idx;
    logic             load;
    logic [WIDTH-1:0] load_data;

    assign valid_out = (state_q == OUT_FULL);
    assign data_out  = data_q;
    assign chan_out  = chan_q;

    // The register can accept a word when empty or when it drains this edge.
    assign can_load = !valid_out || ready_in;

    // Selector mode: grant only an in-range selector whose channel is valid.
    always_comb begin
        sel_exists = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((int'(selector) == i) && valid_in[i]) begin
                sel_exists = 1'b1;
            end
        end
    end

`ifdef MUX_PARAM_RR_EN
    logic             use_rr;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_exists;

    assign use_rr = (mode == MODE_RR);

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .clk            (clk),
        .reset_L        (reset_L),
        .valid_i        (valid_in),
        .advance_i      (load && use_rr),
        .grant_o        (rr_grant),
        .grant_exists_o (rr_exists)
    );

    assign grant_idx    = use_rr ? rr_grant  : selector;
    assign grant_exists = use_rr ? rr_exists : sel_exists;
`else
    // Mode has no effect without the arbiter.
    logic unused_mode;
    assign unused_mode  = mode;
    assign grant_idx    = selector;
    assign grant_exists = sel_exists;
`endif

    // A grant is taken only out of reset and when the register has room.
    assign load = reset_L && can_load && grant_exists;

    // One-hot accept toward the granted channel.
    always_comb begin
        ready_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load && (int'(grant_idx) == i)) begin
                ready_out[i] = 1'b1;
            end
        end
    end

    // Pick the granted channel's word; out-of-range indices select nothing.
    always_comb begin
        load_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(grant_idx) == i) begin
                load_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output-stage next state: load wins over drain, so no bubble on refill.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        case (state_q)
            OUT_EMPTY: begin
                if (load) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (!load && ready_in) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase
        if (load) begin
            data_d = load_data;
            chan_d = grant_idx;
        end
    end

    // Output register; an asserted reset drops the held word at once.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= OUT_EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

endmodule

// File: doc/mux_param_rr.md
# mux_param_rr

Parametrised, registered N-channel multiplexer with a per-channel valid/ready handshake and an optional round-robin arbitration mode. It generalises the 2-bit 2:1 registered mux pair (behavioural and structural) to WIDTH bits and CHANNELS inputs. It adds downstream backpressure, reports which channel was selected, and lets channels be granted fairly without a driven selector. It sits between multiple lane producers and a single consumer.

## Interface
- WIDTH, 2: data bits per channel (≥1).
- CHANNELS, 4: number of input channels (≥2; non-power-of-2 allowed).
- SEL_W, derived localparam = clog2(CHANNELS): selector/channel-index width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- mode  in  1  0 = selector mode, 1 = round-robin mode (see Configuration).
- selector  in  SEL_W  channel to pass in selector mode.
- valid_in  in  CHANNELS  per-channel data valid.
- data_in  in  CHANNELS*WIDTH  flattened inputs; channel i at [i*WIDTH +: WIDTH].
- ready_out  out  CHANNELS  per-channel accept, combinational, one-hot or zero.
- ready_in  in  1  downstream ready.
- valid_out  out  1  output register holds a word.
- data_out  out  WIDTH  registered selected word.
- chan_out  out  SEL_W  index of the channel that supplied data_out.

## Operation
- Output stage: one-entry register, states EMPTY (valid_out=0) and FULL (valid_out=1).
- can_load = !valid_out | ready_in. Only when can_load is high can a channel be granted.
- Selector mode: grant = selector if selector < CHANNELS and valid_in[selector]; otherwise no grant.
- Round-robin mode: grant = first i with valid_in[i], searching ptr+1, ptr+2, … with wrap modulo CHANNELS. If no channel is valid, there is no grant.
- ready_out[grant] = can_load & grant_exists; all other bits are 0.
- On a grant edge:
  - data_out ← data_in[grant].
  - chan_out ← grant.
  - valid_out ← 1.
  - In round-robin mode, ptr ← grant.
- On an edge with valid_out & ready_in and no grant: valid_out ← 0. data_out and chan_out hold their last values.
- Simultaneous drain and grant: the new word loads with no bubble, and valid_out stays 1.
- Backpressure (valid_out & !ready_in): data_out and chan_out are held stable, ready_out = 0, and ptr is frozen.
- A mode change takes effect at the next grant evaluation. ptr is preserved across mode changes and is not updated in selector mode.
- Out-of-range selector (≥ CHANNELS): nothing is granted and no channel sees ready_out.

## Timing
- Reset values (async assert, sync-to-clk release): valid_out=0, data_out=0, chan_out=0, ptr=CHANNELS-1, so the first round-robin search starts at channel 0.
- ready_out is 0 while reset_L=0.
- Latency: accepted word appears on data_out/valid_out 1 cycle after the accepting edge.
- Throughput: 1 word/cycle while ready_in=1 and a grant exists every cycle.
- Reset mid-operation discards the held word immediately, without waiting for a clock edge.
- Round-robin fairness: with all channels continuously valid and ready_in=1, the grant sequence is 0,1,…,CHANNELS-1,0,…

## Configuration
- MUX_PARAM_RR_EN defined: round-robin logic, ptr and the mode input are functional.
- Not defined: the mode input is ignored and the block operates in selector mode only. ptr and the arbiter are not instantiated. All other behaviour is identical.

## Structure
- Shared package mux_pkg:
  - mode encodings MODE_SEL=1'b0 and MODE_RR=1'b1;
  - clog2 helper used for SEL_W.
- Sub-module rr_arbiter (CHANNELS parameter). It holds ptr and produces the grant index and grant_exists from valid_in and an advance enable, and is instantiated only under MUX_PARAM_RR_EN.
- Top level contains the selector-mode grant, the ready_out decode and the output register.

## Test plan
- Reset: reset_L=0 with all valid_in=1 → valid_out=0, data_out=0, chan_out=0, ready_out=0.
- Selector mode, WIDTH=2, CHANNELS=4:
  - Setup: selector=2, valid_in=4'b0100, data_in ch2=2'b11, ready_in=1.
  - Required: ready_out=4'b0100; next cycle data_out=2'b11, chan_out=2, valid_out=1.
- Backpressure:
  - Setup: FULL with data_out=2'b01; ready_in=0 for 3 cycles while ch0 is valid with 2'b10.
  - Required: data_out held at 2'b01 and ready_out=0 throughout.
  - Then: on ready_in=1, 2'b10 loads the same edge and valid_out stays 1.
- Round-robin (MUX_PARAM_RR_EN defined):
  - Setup: mode=1, valid_in=4'b1111, channel i drives data i, ready_in=1.
  - Required: chan_out sequence 0,1,2,3,0; then with valid_in=4'b1010 the sequence is 1,3,1.
- Out-of-range selector: CHANNELS=3, selector=3 → ready_out=3'b000, valid_out falls to 0 after draining.
- Mid-stream reset: assert reset_L=0 between edges while FULL → valid_out=0 immediately. After release, round-robin restarts at channel 0.
